// File: rtl/riscv_hwloop_cfg_sequencer_if.sv
// Purpose: groups the loop-config request, CSR write, decrement tracking and
//          register-set output signals of the hardware-loop config sequencer.
// Ports:   master = ID/CSR/jump-logic side, slave = sequencer side.
interface riscv_hwloop_cfg_sequencer_if #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
);
    // ID-stage loop configuration request
    logic                         id_req_valid_i;
    logic                         id_req_ready_o;
    logic [N_REG_BITS-1:0]        id_req_regid_i;
    logic [1:0]                   id_req_op_i;
    logic [31:0]                  id_start_i;
    logic [31:0]                  id_end_i;
    logic [31:0]                  id_cnt_i;
    // CSR write port
    logic                         csr_we_i;
    logic                         csr_ready_o;
    logic [N_REG_BITS-1:0]        csr_regid_i;
    logic [1:0]                   csr_sel_i;
    logic [31:0]                  csr_wdata_i;
    // Decrement tracking
    logic [N_REGS-1:0]            hwlp_dec_req_i;
    logic                         commit_i;
    logic                         flush_i;
    // Register set
    logic [N_REGS-1:0][31:0]      hwlp_start_addr_o;
    logic [N_REGS-1:0][31:0]      hwlp_end_addr_o;
    logic [N_REGS-1:0][31:0]      hwlp_counter_o;
    logic [N_REGS-1:0]            hwlp_dec_pending_o;
    logic                         busy_o;

    modport master (
        output id_req_valid_i, id_req_regid_i, id_req_op_i, id_start_i, id_end_i, id_cnt_i,
        output csr_we_i, csr_regid_i, csr_sel_i, csr_wdata_i,
        output hwlp_dec_req_i, commit_i, flush_i,
        input  id_req_ready_o, csr_ready_o,
        input  hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o, hwlp_dec_pending_o, busy_o
    );

    modport slave (
        input  id_req_valid_i, id_req_regid_i, id_req_op_i, id_start_i, id_end_i, id_cnt_i,
        input  csr_we_i, csr_regid_i, csr_sel_i, csr_wdata_i,
        input  hwlp_dec_req_i, commit_i, flush_i,
        output id_req_ready_o, csr_ready_o,
        output hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o, hwlp_dec_pending_o, busy_o
    );
endinterface

// File: rtl/riscv_hwloop_cfg_sequencer.sv
// Purpose: owns the hwloop start/end/counter registers, applies ID and CSR
//          config writes, and tracks in-flight decrements until commit/flush.
// Ports:   clk, rst_n (async active-low), bus (slave modport of the _if).
//          Register outputs update one edge after the accepting handshake;
//          an ID request to a loop with a pending decrement stalls (DRAIN).
module riscv_hwloop_cfg_sequencer #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    riscv_hwloop_cfg_sequencer_if.slave     bus
);

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_END   = 2'd1;
    localparam logic [1:0] OP_COUNT = 2'd2;
    localparam logic [1:0] OP_SETUP = 2'd3;

    localparam logic [1:0] SEL_START = 2'd0;
    localparam logic [1:0] SEL_END   = 2'd1;
    localparam logic [1:0] SEL_CNT   = 2'd2;

    typedef enum logic [1:0] {IDLE, DRAIN, WRITE} state_t;

    state_t                  state_q, state_d;
    logic [N_REGS-1:0]       pending_q;
    logic [N_REGS-1:0][31:0] start_q, end_q, cnt_q;

    logic id_in_range, csr_in_range, pend_sel;
    logic id_ready, id_wr, csr_ready;

    // Out-of-range indices are accepted but never match a register.
    assign id_in_range  = 32'(bus.id_req_regid_i) < N_REGS;
    assign csr_in_range = 32'(bus.csr_regid_i) < N_REGS;
    assign pend_sel     = id_in_range && pending_q[bus.id_req_regid_i];

    always_comb begin
        state_d  = state_q;
        id_ready = 1'b0;
        id_wr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.id_req_valid_i) begin
                    if (pend_sel) begin
                        state_d = DRAIN;
                    end else begin
                        id_ready = 1'b1;
                        id_wr    = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!bus.id_req_valid_i) begin
                    state_d = IDLE;
                end else if (!pend_sel) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = IDLE;
                if (bus.id_req_valid_i) begin
                    id_ready = 1'b1;
                    id_wr    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ID path has priority: CSR is only accepted when the ID side is silent.
    assign csr_ready = bus.csr_we_i && (state_q == IDLE) && !bus.id_req_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            start_q   <= '0;
            end_q     <= '0;
            cnt_q     <= '0;
        end else begin
            for (int j = 0; j < N_REGS; j++) begin
                // A new request in the commit cycle keeps the bit set; flush kills everything.
                if (bus.flush_i) begin
                    pending_q[j] <= 1'b0;
                end else begin
                    pending_q[j] <= bus.hwlp_dec_req_i[j] | (pending_q[j] & ~bus.commit_i);
                end

                if (bus.commit_i && !bus.flush_i && pending_q[j] && cnt_q[j] != 32'd0) begin
                    cnt_q[j] <= cnt_q[j] - 32'd1;
                end

                // Writes are placed after the decrement so they win on the same edge.
                if (id_wr && id_in_range && bus.id_req_regid_i == N_REG_BITS'(j)) begin
                    if (bus.id_req_op_i == OP_START || bus.id_req_op_i == OP_SETUP)
                        start_q[j] <= bus.id_start_i;
                    if (bus.id_req_op_i == OP_END || bus.id_req_op_i == OP_SETUP)
                        end_q[j] <= bus.id_end_i;
                    if (bus.id_req_op_i == OP_COUNT || bus.id_req_op_i == OP_SETUP)
                        cnt_q[j] <= bus.id_cnt_i;
                end

                if (csr_ready && csr_in_range && bus.csr_regid_i == N_REG_BITS'(j)) begin
                    case (bus.csr_sel_i)
                        SEL_START: start_q[j] <= bus.csr_wdata_i;
                        SEL_END:   end_q[j]   <= bus.csr_wdata_i;
                        SEL_CNT:   cnt_q[j]   <= bus.csr_wdata_i;
                        default:   ;
                    endcase
                end
            end
        end
    end

    assign bus.id_req_ready_o     = id_ready;
    assign bus.csr_ready_o        = csr_ready;
    assign bus.hwlp_start_addr_o  = start_q;
    assign bus.hwlp_end_addr_o    = end_q;
    assign bus.hwlp_counter_o     = cnt_q;
    assign bus.hwlp_dec_pending_o = pending_q;
    assign bus.busy_o             = (state_q != IDLE);

endmodule

// File: doc/riscv_hwloop_cfg_sequencer.md
Name: riscv_hwloop_cfg_sequencer

Overview:
Owns the hardware-loop register set (start, end, counter per loop) that feeds the hwloop comparator/jump logic. It sequences loop-configuration writes from the ID stage (lp.setup/lp.start/lp.end/lp.count) and CSR writes into the registers. It tracks decrement requests from the jump logic that are still in flight until they commit or are flushed. A setup to a loop with an in-flight decrement is stalled until that decrement drains, so configuration never races a pending decrement.

Parameters:
N_REGS, 2, number of hardware loops
N_REG_BITS, $clog2(N_REGS) (min 1), width of loop index

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_req_valid_i  in  1  ID-stage loop-config request
id_req_ready_o  out  1  request accepted this cycle (valid&ready)
id_req_regid_i  in  N_REG_BITS  target loop
id_req_op_i  in  2  0=START, 1=END, 2=COUNT, 3=SETUP (all three)
id_start_i  in  32  start address
id_end_i  in  32  end address
id_cnt_i  in  32  iteration count
csr_we_i  in  1  CSR write strobe
csr_ready_o  out  1  CSR write accepted
csr_regid_i  in  N_REG_BITS  CSR target loop
csr_sel_i  in  2  0=start, 1=end, 2=counter, 3=reserved (ignored)
csr_wdata_i  in  32  CSR write data
hwlp_dec_req_i  in  N_REGS  decrement request from jump logic (one-hot or zero)
commit_i  in  1  oldest in-flight decrement retires
flush_i  in  1  pipeline kill; all in-flight decrements discarded
hwlp_start_addr_o  out  N_REGS x 32  start registers
hwlp_end_addr_o  out  N_REGS x 32  end registers
hwlp_counter_o  out  N_REGS x 32  counter registers
hwlp_dec_pending_o  out  N_REGS  decrement in flight per loop
busy_o  out  1  FSM not IDLE

Behaviour:
- Reset: all start/end/counter registers 0, hwlp_dec_pending_o 0, FSM IDLE, busy_o 0.
- Pending tracking: hwlp_dec_req_i[j] sets pending[j] at next edge. commit_i with pending[j] set clears it and decrements counter[j] the same edge. flush_i clears all pending bits without decrementing; flush has priority over commit. Request and commit in the same cycle for the same j: counter decrements and pending stays 1.
- Counter arithmetic: 32-bit unsigned; a decrement at 0 saturates at 0 (no wrap).
- FSM states: IDLE, DRAIN, WRITE.
- IDLE:
  - id_req_ready_o = id_req_valid_i & ~pending[regid].
  - On handshake, the selected field(s) are written at that edge; SETUP writes all three atomically.
  - Valid with pending[regid]=1 -> DRAIN, ready 0.
- DRAIN: ready 0; when pending[regid]=0 (after commit or flush) -> WRITE. Requester holds valid/regid/op/data stable.
- WRITE: ready 1; write occurs; -> IDLE next cycle. Valid dropped in DRAIN/WRITE -> IDLE, no write.
- Register write vs decrement: a config or CSR write to a counter wins over a same-cycle commit decrement of that counter (write value stored, pending still cleared).
- CSR arbitration: csr_ready_o = csr_we_i & (FSM==IDLE) & ~id_req_valid_i. The ID path has priority; CSR writes are held by the requester until ready. Write lands at the accepting edge.
- Out-of-range regid (>= N_REGS): ID request is accepted in IDLE and dropped; CSR write is accepted and dropped. csr_sel=3: accepted, no effect.
- Latency: register outputs update one edge after handshake; no combinational path from inputs to the register outputs.
- Reset mid-DRAIN/WRITE: immediately to IDLE, all state cleared.

Test Plan:
- Reset then SETUP loop0 start=0x100 end=0x120 cnt=5, no pending -> ready same cycle; next cycle outputs 0x100/0x120/5, busy_o 0.
- dec_req[0] pulse, commit two cycles later -> pending[0]=1 for 2 cycles, then counter 5->4; counter at 0 plus commit -> stays 0.
- dec_req[1] then SETUP loop1 cnt=9 -> ready 0, busy_o 1 (DRAIN); commit -> WRITE, ready 1, counter1=9 (not 8).
- Pending[0] set, flush_i with commit_i together -> pending cleared, counter unchanged.
- CSR write counter loop1=0x33 while ID valid -> csr_ready_o 0; ID done -> csr_ready_o 1, counter1=0x33.
- rst_n low during DRAIN -> FSM IDLE, all outputs 0 asynchronously.
